plot_sequencer: RTL and testbench

Owns the single pixel-write port (x, y, color, plot) into the 160x120 frame buffer. Accepts one command at a time and either raster-scans the whole screen itself (CLEAR or FILL) or grants the port to the external line engine and forwards its pixels. It sits between the top-level command source and the VGA adapter. Its `done` pulse sequences the next command.

---
 rtl/plot_pkg.sv | 23 ++
 rtl/raster_scan.sv | 42 ++++
 rtl/plot_sequencer.sv | 168 ++++++++++++++++
 tb/tb_plot_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared types and widths for the plot sequencer: command encodings,
// controller states and frame-buffer coordinate/color widths.
package plot_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_FILL  = 2'b01,
    OP_LINE  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    LINE = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/raster_scan.sv
// Raster x/y counter: x runs 0..H_RES-1, then wraps and bumps y; both wrap
// to 0 after the final pixel. 'last' flags the (H_RES-1, V_RES-1) position.
module raster_scan
  import plot_pkg::*;
#(
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           clear,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (enable) begin
      if (x_reg == X_LAST) begin
        x_reg <= '0;
        y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + Y_W'(1);
      end else begin
        x_reg <= x_reg + X_W'(1);
      end
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign last = (x_reg == X_LAST) && (y_reg == Y_LAST);

endmodule

// File: rtl/plot_sequencer.sv
// Owns the frame-buffer pixel port: raster-fills the screen for CLEAR/FILL or
// forwards line-engine pixels for LINE. Optional back-pressure: PLOT_STALL_EN.
module plot_sequencer
  import plot_pkg::*;
#(
  parameter int             H_RES     = 160,
  parameter int             V_RES     = 120,
  parameter logic [C_W-1:0] CLR_COLOR = 3'b000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  input  logic [1:0]     cmd_op,
  output logic           cmd_ready,
  output logic           line_gnt,
  input  logic           line_valid,
  input  logic [X_W-1:0] line_x,
  input  logic [Y_W-1:0] line_y,
  input  logic [C_W-1:0] line_color,
  input  logic           line_last,
  output logic           line_ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] color,
  output logic           plot,
  output logic           busy,
`ifdef PLOT_STALL_EN
  input  logic           plot_ready,
`endif
  output logic           done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  state_e         state_reg, state_next;
  logic           fin_reg, fin_next;
  logic           fill_reg, fill_next;
  logic [X_W-1:0] x_reg, x_next;
  logic [Y_W-1:0] y_reg, y_next;
  logic [C_W-1:0] color_reg, color_next;
  logic           plot_reg, plot_next;

  logic           stall;
  logic           scan_en, scan_clear, scan_last;
  logic [X_W-1:0] scan_x;
  logic [Y_W-1:0] scan_y;
  logic           line_in_range;
  op_e            op;

`ifdef PLOT_STALL_EN
  assign stall = plot_reg & ~plot_ready;
`else
  assign stall = 1'b0;
`endif

  assign op            = op_e'(cmd_op);
  assign line_in_range = (line_x <= X_LAST) && (line_y <= Y_LAST);
  assign scan_en       = (state_reg == SCAN) && !fin_reg && !stall;
  assign scan_clear    = (state_reg == IDLE) && cmd_valid;

  raster_scan #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_raster_scan (
    .clk   (clk),
    .reset (reset),
    .enable(scan_en),
    .clear (scan_clear),
    .x     (scan_x),
    .y     (scan_y),
    .last  (scan_last)
  );

  // fin_reg marks "final pixel is on the port"; the next committed cycle enters DONE.
  always_comb begin
    state_next = state_reg;
    fin_next   = fin_reg;
    fill_next  = fill_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    color_next = color_reg;
    plot_next  = stall;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          fin_next = 1'b0;
          case (op)
            OP_CLEAR: begin
              state_next = SCAN;
              fill_next  = 1'b0;
            end
            OP_FILL: begin
              state_next = SCAN;
              fill_next  = 1'b1;
            end
            OP_LINE: state_next = LINE;
            default: state_next = DONE;
          endcase
        end
      end
      SCAN: begin
        if (!stall) begin
          if (fin_reg) begin
            state_next = DONE;
            fin_next   = 1'b0;
          end else begin
            x_next     = scan_x;
            y_next     = scan_y;
            color_next = fill_reg ? scan_y[C_W-1:0] : CLR_COLOR;
            plot_next  = 1'b1;
            fin_next   = scan_last;
          end
        end
      end
      LINE: begin
        if (!stall) begin
          if (fin_reg) begin
            state_next = DONE;
            fin_next   = 1'b0;
          end else if (line_valid) begin
            // Out-of-range pixels are consumed but never written.
            if (line_in_range) begin
              x_next     = line_x;
              y_next     = line_y;
              color_next = line_color;
              plot_next  = 1'b1;
            end
            fin_next = line_last;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      fin_reg   <= 1'b0;
      fill_reg  <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      color_reg <= '0;
      plot_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      fin_reg   <= fin_next;
      fill_reg  <= fill_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      color_reg <= color_next;
      plot_reg  <= plot_next;
    end
  end

  assign x          = x_reg;
  assign y          = y_reg;
  assign color      = color_reg;
  assign plot       = plot_reg;
  assign cmd_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign line_gnt   = (state_reg == LINE);
  assign line_ready = (state_reg == LINE) && !fin_reg && !stall;

endmodule

// File: tb/tb_plot_sequencer.sv
// Self-checking bench for plot_sequencer: full CLEAR/FILL scans, directed and
// random LINE streams, clipping, mid-scan reset and held/reserved commands.
module tb_plot_sequencer;

  localparam int H = 160;
  localparam int V = 120;
  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_FILL  = 2'b01;
  localparam logic [1:0] C_LINE  = 2'b10;
  localparam logic [1:0] C_RSVD  = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready, line_gnt, line_ready, plot, busy, done;
  logic       line_valid = 1'b0;
  logic [7:0] line_x = '0;
  logic [6:0] line_y = '0;
  logic [2:0] line_color = '0;
  logic       line_last = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;

  int vectors = 0;
  int miscompares = 0;

  // Last written pixel; outputs must hold it whenever plot is low.
  int ex_x = 0, ex_y = 0, ex_c = 0;
  int lx[$], ly[$], lc[$];

  plot_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .line_gnt(line_gnt), .line_valid(line_valid),
    .line_x(line_x), .line_y(line_y), .line_color(line_color),
    .line_last(line_last), .line_ready(line_ready), .x(x), .y(y),
    .color(color), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_x"}, x, ex_x);
    check({tag, "_y"}, y, ex_y);
    check({tag, "_c"}, color, ex_c);
  endtask

  // Full or aborted raster scan; optionally keeps cmd_valid high (reserved op) throughout.
  task automatic do_scan(input logic [1:0] op, input bit hold_rsvd, input int abort_at);
    int px, py, ec;
    @(negedge clk);
    check("scan_rdy_pre", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    if (hold_rsvd) cmd_op = C_RSVD;
    else cmd_valid = 1'b0;
    check("scan_busy", busy, 1);
    check("scan_plot0", plot, 0);
    for (int k = 0; k < H * V; k++) begin
      @(negedge clk);
      px = k % H;
      py = k / H;
      ec = (op == C_FILL) ? (py % 8) : 0;
      ex_x = px; ex_y = py; ex_c = ec;
      check("scan_plot", plot, 1);
      check_hold("scan_pix");
      check("scan_done", done, 0);
      check("scan_rdy", cmd_ready, 0);
      if (k == abort_at) begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ex_x = 0; ex_y = 0; ex_c = 0;
        check("rst_plot", plot, 0);
        check_hold("rst_pix");
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("rst_nodone", done, 0);
          check("rst_noplot", plot, 0);
        end
        return;
      end
    end
    @(negedge clk);
    check("end_done", done, 1);
    check("end_plot", plot, 0);
    check("end_rdy", cmd_ready, 0);
    check_hold("end_hold");
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_rdy", cmd_ready, 1);
    check("idle_busy", busy, 0);
    if (hold_rsvd) begin
      // Held reserved op is accepted on this edge: done next cycle, no plots.
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rsvd_done", done, 1);
      check("rsvd_plot", plot, 0);
      check("rsvd_rdy", cmd_ready, 0);
      check_hold("rsvd_hold");
      @(negedge clk);
      check("rsvd_idle", cmd_ready, 1);
      check("rsvd_done0", done, 0);
      check("rsvd_plot0", plot, 0);
    end
  endtask

  // Feeds the pixels in lx/ly/lc; gap_pct is the chance of an idle cycle.
  task automatic do_line(input int gap_pct);
    int idx = 0;
    int phase = 0;  // 0 feeding, 1 last pixel on port, 2 done cycle
    bit finished = 0;
    bit e_plot = 0;
    @(negedge clk);
    check("line_rdy_pre", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = C_LINE;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      check("line_plot", plot, e_plot);
      check_hold("line_pix");
      check("line_gnt", line_gnt, phase < 2);
      check("line_ready", line_ready, phase == 0);
      check("line_done", done, phase == 2);
      if (phase == 2) begin
        finished = 1;
        break;
      end
      line_x = 8'($urandom_range(0, 255));
      line_y = 7'($urandom_range(0, 127));
      line_color = 3'($urandom);
      line_last = 1'($urandom);
      line_valid = (phase != 0) ? 1'($urandom) : 1'b0;
      e_plot = 0;
      if (phase == 1) begin
        phase = 2;
      end else if (phase == 0 && $urandom_range(0, 99) >= gap_pct) begin
        line_valid = 1'b1;
        line_x = 8'(lx[idx]);
        line_y = 7'(ly[idx]);
        line_color = 3'(lc[idx]);
        line_last = (idx == lx.size() - 1);
        if (lx[idx] < H && ly[idx] < V) begin
          e_plot = 1;
          ex_x = lx[idx]; ex_y = ly[idx]; ex_c = lc[idx];
        end
        if (idx == lx.size() - 1) phase = 1;
        idx++;
      end
      @(negedge clk);
    end
    line_valid = 1'b0;
    line_last = 1'b0;
    if (!finished) check("line_timeout", 0, 1);
    @(negedge clk);
    check("line_idle_rdy", cmd_ready, 1);
    check("line_idle_done", done, 0);
    check("line_idle_plot", plot, 0);
  endtask

  task automatic push_pix(input int px, input int py, input int pc);
    lx.push_back(px);
    ly.push_back(py);
    lc.push_back(pc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_color", color, 0);
    check("rst_plot", plot, 0);
    check("rst_done", done, 0);
    check("rst_gnt", line_gnt, 0);
    check("rst_lready", line_ready, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // FILL with a reserved op held high throughout the scan.
    do_scan(C_FILL, 1'b1, -1);

    // CLEAR aborted by reset at pixel (80,60), then a full CLEAR from (0,0).
    do_scan(C_CLEAR, 1'b0, 60 * H + 80);
    do_scan(C_CLEAR, 1'b0, -1);

    // Back-to-back directed line.
    lx.delete(); ly.delete(); lc.delete();
    push_pix(10, 10, 3); push_pix(11, 11, 3); push_pix(12, 12, 3);
    do_line(0);

    // Clipping: two out-of-range pixels, then the far corner.
    lx.delete(); ly.delete(); lc.delete();
    push_pix(160, 5, 2); push_pix(5, 120, 4); push_pix(159, 119, 6);
    do_line(0);

    // Random lines with gaps and occasional out-of-range coordinates.
    for (int r = 0; r < 6; r++) begin
      int n;
      lx.delete(); ly.delete(); lc.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        push_pix($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
      do_line(40);
    end

    // Reserved op from a plain idle.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = C_RSVD;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rsvd2_done", done, 1);
    check("rsvd2_plot", plot, 0);
    @(negedge clk);
    check("rsvd2_rdy", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
